// File: rtl/sha2_compress_iter.sv
// Iterative SHA-256 / SHA-512 compression core: one round per clock,
// 16-word sliding message-schedule window, single-entry job with valid/ready on both sides.
module sha2_compress_iter #(
  parameter int WORDSIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORDSIZE-1:0]   H_in,
  input  logic [16*WORDSIZE-1:0]  M_in,
  input  logic                    input_valid,
  output logic                    input_ready,
  output logic [8*WORDSIZE-1:0]   H_out,
  output logic                    output_valid,
  input  logic                    output_ready
);

  localparam int ROUNDS = (WORDSIZE == 32) ? 64 : 80;
  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  generate
    if (WORDSIZE != 32 && WORDSIZE != 64) begin : g_bad_wordsize
      $error("sha2_compress_iter: WORDSIZE must be 32 or 64");
    end
  endgenerate

  // FIPS 180-4 rotate/shift amounts; the third sigma term is a plain shift.
  localparam int BS0_A = (WORDSIZE == 32) ? 2  : 28;
  localparam int BS0_B = (WORDSIZE == 32) ? 13 : 34;
  localparam int BS0_C = (WORDSIZE == 32) ? 22 : 39;
  localparam int BS1_A = (WORDSIZE == 32) ? 6  : 14;
  localparam int BS1_B = (WORDSIZE == 32) ? 11 : 18;
  localparam int BS1_C = (WORDSIZE == 32) ? 25 : 41;
  localparam int SS0_A = (WORDSIZE == 32) ? 7  : 1;
  localparam int SS0_B = (WORDSIZE == 32) ? 18 : 8;
  localparam int SS0_C = (WORDSIZE == 32) ? 3  : 7;
  localparam int SS1_A = (WORDSIZE == 32) ? 17 : 19;
  localparam int SS1_B = (WORDSIZE == 32) ? 19 : 61;
  localparam int SS1_C = (WORDSIZE == 32) ? 10 : 6;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [6:0]            r_t;
  logic [WORDSIZE-1:0]   r_wk  [8];
  logic [WORDSIZE-1:0]   r_hin [8];
  logic [WORDSIZE-1:0]   r_w   [16];
  logic [8*WORDSIZE-1:0] r_hout;

  logic                  w_accept;
  logic [WORDSIZE-1:0]   w_k;
  logic [WORDSIZE-1:0]   w_t1;
  logic [WORDSIZE-1:0]   w_t2;
  logic [WORDSIZE-1:0]   w_wnew;
  logic [8*WORDSIZE-1:0] w_hsum;

  function automatic logic [WORDSIZE-1:0] rotr(input logic [WORDSIZE-1:0] x, input int n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic logic [WORDSIZE-1:0] bsig0(input logic [WORDSIZE-1:0] x);
    return rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
  endfunction

  function automatic logic [WORDSIZE-1:0] bsig1(input logic [WORDSIZE-1:0] x);
    return rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
  endfunction

  function automatic logic [WORDSIZE-1:0] ssig0(input logic [WORDSIZE-1:0] x);
    return rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_C);
  endfunction

  function automatic logic [WORDSIZE-1:0] ssig1(input logic [WORDSIZE-1:0] x);
    return rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_C);
  endfunction

  // SHA-256 constants are exactly the upper 32 bits of the first 64 SHA-512 constants.
  function automatic logic [WORDSIZE-1:0] k_const(input logic [6:0] idx);
    logic [63:0] k;
    case (idx)
      7'd0:  k = 64'h428a2f98d728ae22;  7'd1:  k = 64'h7137449123ef65cd;
      7'd2:  k = 64'hb5c0fbcfec4d3b2f;  7'd3:  k = 64'he9b5dba58189dbbc;
      7'd4:  k = 64'h3956c25bf348b538;  7'd5:  k = 64'h59f111f1b605d019;
      7'd6:  k = 64'h923f82a4af194f9b;  7'd7:  k = 64'hab1c5ed5da6d8118;
      7'd8:  k = 64'hd807aa98a3030242;  7'd9:  k = 64'h12835b0145706fbe;
      7'd10: k = 64'h243185be4ee4b28c;  7'd11: k = 64'h550c7dc3d5ffb4e2;
      7'd12: k = 64'h72be5d74f27b896f;  7'd13: k = 64'h80deb1fe3b1696b1;
      7'd14: k = 64'h9bdc06a725c71235;  7'd15: k = 64'hc19bf174cf692694;
      7'd16: k = 64'he49b69c19ef14ad2;  7'd17: k = 64'hefbe4786384f25e3;
      7'd18: k = 64'h0fc19dc68b8cd5b5;  7'd19: k = 64'h240ca1cc77ac9c65;
      7'd20: k = 64'h2de92c6f592b0275;  7'd21: k = 64'h4a7484aa6ea6e483;
      7'd22: k = 64'h5cb0a9dcbd41fbd4;  7'd23: k = 64'h76f988da831153b5;
      7'd24: k = 64'h983e5152ee66dfab;  7'd25: k = 64'ha831c66d2db43210;
      7'd26: k = 64'hb00327c898fb213f;  7'd27: k = 64'hbf597fc7beef0ee4;
      7'd28: k = 64'hc6e00bf33da88fc2;  7'd29: k = 64'hd5a79147930aa725;
      7'd30: k = 64'h06ca6351e003826f;  7'd31: k = 64'h142929670a0e6e70;
      7'd32: k = 64'h27b70a8546d22ffc;  7'd33: k = 64'h2e1b21385c26c926;
      7'd34: k = 64'h4d2c6dfc5ac42aed;  7'd35: k = 64'h53380d139d95b3df;
      7'd36: k = 64'h650a73548baf63de;  7'd37: k = 64'h766a0abb3c77b2a8;
      7'd38: k = 64'h81c2c92e47edaee6;  7'd39: k = 64'h92722c851482353b;
      7'd40: k = 64'ha2bfe8a14cf10364;  7'd41: k = 64'ha81a664bbc423001;
      7'd42: k = 64'hc24b8b70d0f89791;  7'd43: k = 64'hc76c51a30654be30;
      7'd44: k = 64'hd192e819d6ef5218;  7'd45: k = 64'hd69906245565a910;
      7'd46: k = 64'hf40e35855771202a;  7'd47: k = 64'h106aa07032bbd1b8;
      7'd48: k = 64'h19a4c116b8d2d0c8;  7'd49: k = 64'h1e376c085141ab53;
      7'd50: k = 64'h2748774cdf8eeb99;  7'd51: k = 64'h34b0bcb5e19b48a8;
      7'd52: k = 64'h391c0cb3c5c95a63;  7'd53: k = 64'h4ed8aa4ae3418acb;
      7'd54: k = 64'h5b9cca4f7763e373;  7'd55: k = 64'h682e6ff3d6b2b8a3;
      7'd56: k = 64'h748f82ee5defb2fc;  7'd57: k = 64'h78a5636f43172f60;
      7'd58: k = 64'h84c87814a1f0ab72;  7'd59: k = 64'h8cc702081a6439ec;
      7'd60: k = 64'h90befffa23631e28;  7'd61: k = 64'ha4506cebde82bde9;
      7'd62: k = 64'hbef9a3f7b2c67915;  7'd63: k = 64'hc67178f2e372532b;
      7'd64: k = 64'hca273eceea26619c;  7'd65: k = 64'hd186b8c721c0c207;
      7'd66: k = 64'heada7dd6cde0eb1e;  7'd67: k = 64'hf57d4f7fee6ed178;
      7'd68: k = 64'h06f067aa72176fba;  7'd69: k = 64'h0a637dc5a2c898a6;
      7'd70: k = 64'h113f9804bef90dae;  7'd71: k = 64'h1b710b35131c471b;
      7'd72: k = 64'h28db77f523047d84;  7'd73: k = 64'h32caab7b40c72493;
      7'd74: k = 64'h3c9ebe0a15c9bebc;  7'd75: k = 64'h431d67c49c100d4c;
      7'd76: k = 64'h4cc5d4becb3e42b6;  7'd77: k = 64'h597f299cfc657e2a;
      7'd78: k = 64'h5fcb6fab3ad6faec;  7'd79: k = 64'h6c44198c4a475817;
      default: k = 64'h0;
    endcase
    return k[63 -: WORDSIZE];
  endfunction

  assign w_accept = (r_state == IDLE) && input_valid && !rst;
  assign w_k      = k_const(r_t);

  // r_wk[0..7] are a..h; r_w[0] is always W[t] for the round in progress.
  assign w_t1   = r_wk[7] + bsig1(r_wk[4]) + ((r_wk[4] & r_wk[5]) ^ (~r_wk[4] & r_wk[6]))
                + w_k + r_w[0];
  assign w_t2   = bsig0(r_wk[0]) + ((r_wk[0] & r_wk[1]) ^ (r_wk[0] & r_wk[2]) ^ (r_wk[1] & r_wk[2]));
  assign w_wnew = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];

  always_comb begin
    w_hsum = '0;
    for (int i = 0; i < 8; i++) begin
      w_hsum[(7-i)*WORDSIZE +: WORDSIZE] = r_hin[i] + r_wk[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (input_valid) w_state_nxt = ROUND;
      ROUND:   if (r_t == LAST_T) w_state_nxt = FINAL;
      FINAL:   w_state_nxt = DONE;
      DONE:    if (output_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_hout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        r_t <= '0;
      end else if (r_state == ROUND) begin
        r_t <= r_t + 7'd1;
      end
      if (r_state == FINAL) begin
        r_hout <= w_hsum;
      end
    end
  end

  // Working state and schedule window carry no reset; every job reloads them on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 8; i++) begin
        r_hin[i] <= H_in[(7-i)*WORDSIZE +: WORDSIZE];
        r_wk[i]  <= H_in[(7-i)*WORDSIZE +: WORDSIZE];
      end
      for (int j = 0; j < 16; j++) begin
        r_w[j] <= M_in[(15-j)*WORDSIZE +: WORDSIZE];
      end
    end else if (r_state == ROUND) begin
      r_wk[0] <= w_t1 + w_t2;
      r_wk[1] <= r_wk[0];
      r_wk[2] <= r_wk[1];
      r_wk[3] <= r_wk[2];
      r_wk[4] <= r_wk[3] + w_t1;
      r_wk[5] <= r_wk[4];
      r_wk[6] <= r_wk[5];
      r_wk[7] <= r_wk[6];
      for (int j = 0; j < 15; j++) begin
        r_w[j] <= r_w[j+1];
      end
      r_w[15] <= w_wnew;
    end
  end

  assign input_ready  = (r_state == IDLE);
  assign output_valid = (r_state == DONE);
  assign H_out        = r_hout;

endmodule
